// File: rtl/grant_burst_ctrl_pkg.sv
// Shared types and constants for the grant-driven burst controller.
// Holds the FSM state encoding, default widths and one-hot grant codes.
package grant_burst_ctrl_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_LEN_W  = 4;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_R0   = 2'b01;
    localparam logic [1:0] GNT_R1   = 2'b10;
    localparam logic [1:0] GNT_BOTH = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_legal_grant(input logic [1:0] g);
        return (g == GNT_R0) || (g == GNT_R1);
    endfunction

endpackage

// File: rtl/grant_burst_ctrl_beat_counter.sv
// Burst beat counter: load, saturating decrement, clear; flags the final beat.
// Registered count, combinational last flag; never decrements below zero.
module beat_counter #(
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [LEN_W-1:0] load_val_i,
    input  logic             dec_i,
    input  logic             clr_i,
    output logic             last_o
);

    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             zero;

    assign zero   = (cnt_q == '0);
    assign last_o = (cnt_q == LEN_W'(1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && !zero) begin
            cnt_d = cnt_q - LEN_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/grant_burst_ctrl.sv
// Turns a one-hot arbiter grant into a length-counted burst; first beat one cycle after grant.
// out_ready low stalls the beat in place; losing the grant mid-burst aborts it.
module grant_burst_ctrl
    import grant_burst_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        grant,
    input  logic [LEN_W-1:0]  len0,
    input  logic [LEN_W-1:0]  len1,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic [1:0]        owner,
    output logic [1:0]        done,
    output logic              abort,
    output logic              err_multi
);

    state_t           state_q, state_d;
    logic [1:0]       owner_q, owner_d;
    logic             abort_q, abort_d;
    logic             err_q, err_d;

    logic [LEN_W-1:0] sel_len;
    logic             cnt_load, cnt_dec, cnt_clr, cnt_last;
    logic             beat;

    assign sel_len = (grant == GNT_R1) ? len1 : len0;
    assign beat    = out_valid && out_ready;

    beat_counter #(
        .LEN_W (LEN_W)
    ) u_beat_counter (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (sel_len),
        .dec_i      (cnt_dec),
        .clr_i      (cnt_clr),
        .last_o     (cnt_last)
    );

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        abort_d  = 1'b0;
        err_d    = err_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_clr  = 1'b0;

        case (state_q)
            IDLE: begin
                if (is_legal_grant(grant)) begin
                    owner_d  = grant;
                    cnt_load = 1'b1;
                    state_d  = (sel_len == '0) ? DONE : XFER;
                end else if (grant == GNT_BOTH) begin
                    err_d = 1'b1;
                end
            end
            XFER: begin
                // Completion wins over a grant change on the final beat.
                if (beat && cnt_last) begin
                    cnt_dec = 1'b1;
                    state_d = DONE;
                end else if (grant != owner_q) begin
                    state_d = IDLE;
                    owner_d = GNT_NONE;
                    abort_d = 1'b1;
                    cnt_clr = 1'b1;
                end else if (beat) begin
                    cnt_dec = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                owner_d = GNT_NONE;
                cnt_clr = 1'b1;
            end
            default: begin
                state_d = IDLE;
                owner_d = GNT_NONE;
                cnt_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= GNT_NONE;
            abort_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            abort_q <= abort_d;
            err_q   <= err_d;
        end
    end

    assign out_valid = (state_q == XFER);
    assign out_last  = out_valid && cnt_last;
    assign busy      = (state_q != IDLE);
    assign owner     = owner_q;
    assign done      = (state_q == DONE) ? owner_q : GNT_NONE;
    assign abort     = abort_q;
    assign err_multi = err_q;

    always_comb begin
        out_data = '0;
        if (out_valid) begin
            case (owner_q)
                GNT_R0:  out_data = data0;
                GNT_R1:  out_data = data1;
                default: out_data = '0;
            endcase
        end
    end

endmodule
